// File: rtl/mcpu_core_pkg.sv
// Shared definitions for the mcpu core fetch path.
//   - Address field widths for the virtual packet PC and page numbers.
//   - Fetch-TLB stage FSM encoding.
//   - pc_vpn(): extracts the virtual page number from a packet PC.
package mcpu_core_pkg;

    localparam int unsigned VIRTPC_W = 28;
    localparam int unsigned VPN_W    = 20;
    localparam int unsigned PPN_W    = 20;
    localparam int unsigned PGOFF_W  = 8;

    typedef enum logic [0:0] {
        FT_RUN,
        FT_MISS
    } ft_state_e;

    function automatic logic [VPN_W-1:0] pc_vpn(input logic [VIRTPC_W-1:0] pc);
        return pc[VIRTPC_W-1:PGOFF_W];
    endfunction

endpackage

// File: rtl/mcpu_core_fetch_tlb_cam.sv
// Fully-associative instruction TLB storage.
//   clk, rst              : core clock, synchronous active-high reset
//   lookup_vpn            : VPN to translate (combinational lookup)
//   lookup_hit/lookup_ppn : hit flag and matching PPN
//   fill_valid/vpn/ppn    : write one translation this cycle
//   inval                 : clear every valid bit
module mcpu_core_fetch_tlb_cam
    import mcpu_core_pkg::*;
#(
    parameter int unsigned ENTRIES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             lookup_hit,
    output logic [PPN_W-1:0] lookup_ppn,
    input  logic             fill_valid,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [PPN_W-1:0] fill_ppn,
    input  logic             inval
);

    localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid;
    logic [VPN_W-1:0]   vpn [ENTRIES];
    logic [PPN_W-1:0]   ppn [ENTRIES];
    logic [PTR_W-1:0]   ptr;

    logic               fill_match;
    logic [PTR_W-1:0]   fill_idx;

    always_comb begin
        lookup_hit = 1'b0;
        lookup_ppn = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid[i] && (vpn[i] == lookup_vpn)) begin
                lookup_hit = 1'b1;
                lookup_ppn = ppn[i];
            end
        end
    end

    // An invalidate in the same cycle logically precedes the fill, so
    // entries being cleared cannot be the overwrite target.
    always_comb begin
        fill_match = 1'b0;
        fill_idx   = ptr;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid[i] && !inval && (vpn[i] == fill_vpn)) begin
                fill_match = 1'b1;
                fill_idx   = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            ptr   <= '0;
        end else begin
            if (inval) begin
                valid <= '0;
            end
            // Later NBA to the filled bit overrides the global clear.
            if (fill_valid) begin
                valid[fill_idx] <= 1'b1;
                vpn[fill_idx]   <= fill_vpn;
                ppn[fill_idx]   <= fill_ppn;
                if (!fill_match) begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mcpu_core_stage_fetch_tlb.sv
// Fetch-TLB pipeline stage: sequential packet PC generation, instruction
// TLB translation and the ft2f output slot.
//   clkrst_core_clk/rst   : core clock, synchronous active-high reset
//   ft2f_readyout/readyin : output slot valid / fetch accepts
//   ft2f_in_virtpc        : packet PC (16-byte units) held in the slot
//   ft2f_in_physpage      : physical page of that packet
//   pipe_flush(_virtpc)   : redirect, highest priority
//   paging_en             : 0 bypasses the TLB (identity page mapping)
//   tlb_miss(_vpn)        : walker request
//   tlb_fill_*            : walker response, one entry per cycle
//   tlb_inval             : invalidate all TLB entries
module mcpu_core_stage_fetch_tlb
    import mcpu_core_pkg::*;
#(
    parameter logic [27:0] RESET_VIRTPC = 28'h0000000,
    parameter int unsigned TLB_ENTRIES  = 4
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst,
    output logic        ft2f_readyout,
    input  logic        ft2f_readyin,
    output logic [19:0] ft2f_in_physpage,
    output logic [27:0] ft2f_in_virtpc,
    input  logic        pipe_flush,
    input  logic [27:0] pipe_flush_virtpc,
    input  logic        paging_en,
    output logic        tlb_miss,
    output logic [19:0] tlb_miss_vpn,
    input  logic        tlb_fill_valid,
    input  logic [19:0] tlb_fill_vpn,
    input  logic [19:0] tlb_fill_ppn,
    input  logic        tlb_inval
);

    ft_state_e          state, state_next;
    logic [VIRTPC_W-1:0] pc;
    logic               slot_valid;
    logic [VIRTPC_W-1:0] slot_virtpc;
    logic [PPN_W-1:0]   slot_physpage;
    logic [VPN_W-1:0]   miss_vpn_q;

    logic [VPN_W-1:0]   cur_vpn;
    logic               cam_hit;
    logic [PPN_W-1:0]   cam_ppn;
    logic               translated;
    logic [PPN_W-1:0]   xlate_ppn;
    logic               xfer;
    logic               loadable;
    logic               load;
    logic               enter_miss;

    assign cur_vpn    = pc_vpn(pc);
    assign translated = !paging_en || cam_hit;
    assign xlate_ppn  = paging_en ? cam_ppn : cur_vpn;
    assign xfer       = slot_valid && ft2f_readyin;
    assign loadable   = !slot_valid || ft2f_readyin;

    mcpu_core_fetch_tlb_cam #(
        .ENTRIES (TLB_ENTRIES)
    ) u_cam (
        .clk        (clkrst_core_clk),
        .rst        (clkrst_core_rst),
        .lookup_vpn (cur_vpn),
        .lookup_hit (cam_hit),
        .lookup_ppn (cam_ppn),
        .fill_valid (tlb_fill_valid),
        .fill_vpn   (tlb_fill_vpn),
        .fill_ppn   (tlb_fill_ppn),
        .inval      (tlb_inval)
    );

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state <= FT_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        enter_miss = 1'b0;
        if (pipe_flush) begin
            state_next = FT_RUN;
        end else begin
            case (state)
                FT_RUN: begin
                    if (translated) begin
                        load = loadable;
                    end else begin
                        state_next = FT_MISS;
                        enter_miss = 1'b1;
                    end
                end
                FT_MISS: begin
                    if (tlb_fill_valid || !paging_en) begin
                        state_next = FT_RUN;
                    end
                end
                default: state_next = FT_RUN;
            endcase
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            pc            <= RESET_VIRTPC;
            slot_valid    <= 1'b0;
            slot_virtpc   <= RESET_VIRTPC;
            slot_physpage <= '0;
            miss_vpn_q    <= '0;
        end else if (pipe_flush) begin
            pc         <= pipe_flush_virtpc;
            slot_valid <= 1'b0;
        end else begin
            if (load) begin
                slot_valid    <= 1'b1;
                slot_virtpc   <= pc;
                slot_physpage <= xlate_ppn;
                pc            <= pc + VIRTPC_W'(1);
            end else if (xfer) begin
                slot_valid <= 1'b0;
            end
            if (enter_miss) begin
                miss_vpn_q <= cur_vpn;
            end
        end
    end

    assign ft2f_readyout    = slot_valid;
    assign ft2f_in_virtpc   = slot_virtpc;
    assign ft2f_in_physpage = slot_physpage;
    assign tlb_miss         = (state == FT_MISS);
    assign tlb_miss_vpn     = miss_vpn_q;

endmodule
